// File: rtl/layer_sequencer.sv
// Layer sequencer: walks a per-layer configuration table and launches output-channel
// tiles on a compute engine, chaining feature maps through two ping-pong buffers.
module layer_sequencer #(
  parameter int                    MAX_LAYERS     = 32,
  parameter int                    AXI_ADDR_W     = 32,
  parameter int                    DIM_W          = 16,
  parameter int                    COUT_TILE      = 32,
  parameter logic [AXI_ADDR_W-1:0] IMG_ADDR       = 'h0000_0000,
  parameter logic [AXI_ADDR_W-1:0] OUT_ADDR       = 'h9000_0000,
  parameter logic [AXI_ADDR_W-1:0] BUF0_ADDR      = 'h8000_0000,
  parameter logic [AXI_ADDR_W-1:0] BUF1_ADDR      = 'h8100_0000,
  parameter int                    TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            num_layers,
  input  logic                  cfg_we,
  input  logic [7:0]            cfg_idx,
  input  logic [2:0]            cfg_field,
  input  logic [AXI_ADDR_W-1:0] cfg_wdata,
  input  logic                  tile_done,
  output logic                  tile_start,
  output logic [DIM_W-1:0]      H,
  output logic [DIM_W-1:0]      W,
  output logic [DIM_W-1:0]      Cin,
  output logic [DIM_W-1:0]      Cout,
  output logic [1:0]            mode,
  output logic [DIM_W-1:0]      cout_base,
  output logic [DIM_W-1:0]      cout_len,
  output logic [AXI_ADDR_W-1:0] weight_addr,
  output logic [AXI_ADDR_W-1:0] ifm_addr,
  output logic [AXI_ADDR_W-1:0] ofm_addr,
  output logic [7:0]            layer_idx,
  output logic                  busy,
  output logic                  all_done,
  output logic                  err,
  output logic                  aborted
);

  localparam int IDX_W = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DIM_W-1:0] TILE_D  = DIM_W'(COUT_TILE);
  localparam logic [8:0]       MAX_CNT = 9'(MAX_LAYERS);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_ADVANCE, S_DONE, S_ERR
  } state_t;

  // Configuration table (contents survive reset)
  logic [DIM_W-1:0]      r_tab_h    [MAX_LAYERS];
  logic [DIM_W-1:0]      r_tab_w    [MAX_LAYERS];
  logic [DIM_W-1:0]      r_tab_cin  [MAX_LAYERS];
  logic [DIM_W-1:0]      r_tab_cout [MAX_LAYERS];
  logic [1:0]            r_tab_mode [MAX_LAYERS];
  logic [AXI_ADDR_W-1:0] r_tab_wa   [MAX_LAYERS];
  logic [AXI_ADDR_W-1:0] r_tab_st   [MAX_LAYERS];

  state_t                r_state;
  logic                  r_tile_start;
  logic [DIM_W-1:0]      r_h, r_w, r_cin, r_cout;
  logic [1:0]            r_mode;
  logic [DIM_W-1:0]      r_cout_base, r_cout_len;
  logic [AXI_ADDR_W-1:0] r_weight_addr, r_ifm_addr, r_ofm_addr;
  logic [7:0]            r_layer_idx;
  logic                  r_busy, r_all_done, r_err, r_aborted;
  logic [WD_W-1:0]       r_wdog;
  logic [8:0]            r_count;
  logic [DIM_W-1:0]      r_next_base;
  logic [AXI_ADDR_W-1:0] r_next_waddr;
  logic [AXI_ADDR_W-1:0] r_stride;

  logic                  w_cfg_hit;
  logic [IDX_W-1:0]      w_widx, w_ridx;
  logic [8:0]            w_count_in;
  logic                  w_last_layer;
  logic [DIM_W-1:0]      w_rem;
  logic                  w_more_tiles;
  logic [AXI_ADDR_W-1:0] w_ofm_next;
  logic                  w_entry_bad;

  assign w_cfg_hit    = cfg_we && !r_busy && ({24'd0, cfg_idx} < 32'(MAX_LAYERS));
  assign w_widx       = cfg_idx[IDX_W-1:0];
  assign w_ridx       = r_layer_idx[IDX_W-1:0];
  assign w_count_in   = ({24'd0, num_layers} > 32'(MAX_LAYERS)) ? MAX_CNT : {1'b0, num_layers};
  assign w_last_layer = ({1'b0, r_layer_idx} == (r_count - 9'd1));
  assign w_rem        = r_cout - r_next_base;
  assign w_more_tiles = (r_cout - r_cout_base) > TILE_D;
  // Intermediate maps ping-pong: even layers write BUF1, odd layers write BUF0
  assign w_ofm_next   = w_last_layer ? OUT_ADDR : (r_layer_idx[0] ? BUF0_ADDR : BUF1_ADDR);
  assign w_entry_bad  = (r_tab_cout[w_ridx] == '0) || (r_tab_mode[w_ridx] == 2'd3);

  always_ff @(posedge clk) begin
    if (w_cfg_hit) begin
      case (cfg_field)
        3'd0:    r_tab_h[w_widx]    <= cfg_wdata[DIM_W-1:0];
        3'd1:    r_tab_w[w_widx]    <= cfg_wdata[DIM_W-1:0];
        3'd2:    r_tab_cin[w_widx]  <= cfg_wdata[DIM_W-1:0];
        3'd3:    r_tab_cout[w_widx] <= cfg_wdata[DIM_W-1:0];
        3'd4:    r_tab_mode[w_widx] <= cfg_wdata[1:0];
        3'd5:    r_tab_wa[w_widx]   <= cfg_wdata;
        3'd6:    r_tab_st[w_widx]   <= cfg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_tile_start  <= 1'b0;
      r_h           <= '0;
      r_w           <= '0;
      r_cin         <= '0;
      r_cout        <= '0;
      r_mode        <= '0;
      r_cout_base   <= '0;
      r_cout_len    <= '0;
      r_weight_addr <= '0;
      r_ifm_addr    <= '0;
      r_ofm_addr    <= '0;
      r_layer_idx   <= '0;
      r_busy        <= 1'b0;
      r_all_done    <= 1'b0;
      r_err         <= 1'b0;
      r_aborted     <= 1'b0;
      r_wdog        <= '0;
      r_count       <= '0;
      r_next_base   <= '0;
      r_next_waddr  <= '0;
      r_stride      <= '0;
    end else begin
      r_tile_start <= 1'b0;
      r_all_done   <= 1'b0;
      r_aborted    <= 1'b0;
      // Abort preempts every active state, including a same-cycle tile_done
      if (abort && (r_state != S_IDLE) && (r_state != S_ERR)) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE, S_ERR: begin
            if (start) begin
              r_count     <= w_count_in;
              r_err       <= 1'b0;
              r_layer_idx <= '0;
              r_next_base <= '0;
              if (w_count_in == 9'd0) begin
                r_state <= S_DONE;
              end else begin
                r_state <= S_LOAD;
                r_busy  <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            r_h          <= r_tab_h[w_ridx];
            r_w          <= r_tab_w[w_ridx];
            r_cin        <= r_tab_cin[w_ridx];
            r_cout       <= r_tab_cout[w_ridx];
            r_mode       <= r_tab_mode[w_ridx];
            r_next_base  <= '0;
            r_next_waddr <= r_tab_wa[w_ridx];
            r_stride     <= r_tab_st[w_ridx];
            r_ifm_addr   <= (r_layer_idx == 8'd0) ? IMG_ADDR : r_ofm_addr;
            r_ofm_addr   <= w_ofm_next;
            if (w_entry_bad) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            r_cout_base   <= r_next_base;
            r_cout_len    <= (w_rem > TILE_D) ? TILE_D : w_rem;
            r_weight_addr <= r_next_waddr;
            r_tile_start  <= 1'b1;
            r_wdog        <= '0;
            r_state       <= S_WAIT;
          end
          S_WAIT: begin
            if (tile_done) begin
              r_state <= S_ADVANCE;
            end else if (r_wdog == WD_LAST) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_wdog <= r_wdog + 1'b1;
            end
          end
          S_ADVANCE: begin
            // Tile bases and weight pointers advance by accumulation, not multiply
            if (w_more_tiles) begin
              r_next_base  <= r_cout_base + TILE_D;
              r_next_waddr <= r_weight_addr + r_stride;
              r_state      <= S_ISSUE;
            end else if (w_last_layer) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end else begin
              r_layer_idx <= r_layer_idx + 8'd1;
              r_state     <= S_LOAD;
            end
          end
          S_DONE: begin
            r_all_done <= 1'b1;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tile_start  = r_tile_start;
  assign H           = r_h;
  assign W           = r_w;
  assign Cin         = r_cin;
  assign Cout        = r_cout;
  assign mode        = r_mode;
  assign cout_base   = r_cout_base;
  assign cout_len    = r_cout_len;
  assign weight_addr = r_weight_addr;
  assign ifm_addr    = r_ifm_addr;
  assign ofm_addr    = r_ofm_addr;
  assign layer_idx   = r_layer_idx;
  assign busy        = r_busy;
  assign all_done    = r_all_done;
  assign err         = r_err;
  assign aborted     = r_aborted;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed scenarios plus randomized networks, checked
// against a tile-list model derived from the layer table.
module tb_layer_sequencer;

  localparam int ML = 32;
  localparam int CT = 32;
  localparam int TO = 64;
  localparam logic [31:0] IMG  = 32'h0000_0000;
  localparam logic [31:0] OUTA = 32'h9000_0000;
  localparam logic [31:0] B0   = 32'h8000_0000;
  localparam logic [31:0] B1   = 32'h8100_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, cfg_we, tile_done;
  logic [7:0]  num_layers, cfg_idx;
  logic [2:0]  cfg_field;
  logic [31:0] cfg_wdata;
  logic        tile_start, busy, all_done, err, aborted;
  logic [15:0] H, W, Cin, Cout, cout_base, cout_len;
  logic [1:0]  mode;
  logic [31:0] weight_addr, ifm_addr, ofm_addr;
  logic [7:0]  layer_idx;

  layer_sequencer #(
    .MAX_LAYERS(ML), .AXI_ADDR_W(32), .DIM_W(16), .COUT_TILE(CT),
    .IMG_ADDR(IMG), .OUT_ADDR(OUTA), .BUF0_ADDR(B0), .BUF1_ADDR(B1),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_layers(num_layers),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
    .tile_done(tile_done), .tile_start(tile_start), .H(H), .W(W), .Cin(Cin), .Cout(Cout),
    .mode(mode), .cout_base(cout_base), .cout_len(cout_len), .weight_addr(weight_addr),
    .ifm_addr(ifm_addr), .ofm_addr(ofm_addr), .layer_idx(layer_idx), .busy(busy),
    .all_done(all_done), .err(err), .aborted(aborted)
  );

  // Reference copy of the layer table
  logic [15:0] m_h [ML];
  logic [15:0] m_w [ML];
  logic [15:0] m_cin [ML];
  logic [15:0] m_cout [ML];
  logic [1:0]  m_mode [ML];
  logic [31:0] m_wa [ML];
  logic [31:0] m_st [ML];

  typedef struct {
    int          layer;
    logic [15:0] base;
    logic [15:0] len;
    logic [31:0] wa;
    logic [31:0] ifm;
    logic [31:0] ofm;
    bit          first;
  } tile_t;
  tile_t exp_q[$];

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // A value read here is what the DUT presents to the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input int f, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = 8'(idx); cfg_field = 3'(f); cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    case (f)
      0: m_h[idx]    = d[15:0];
      1: m_w[idx]    = d[15:0];
      2: m_cin[idx]  = d[15:0];
      3: m_cout[idx] = d[15:0];
      4: m_mode[idx] = d[1:0];
      5: m_wa[idx]   = d;
      default: m_st[idx] = d;
    endcase
  endtask

  task automatic set_layer(input int idx, input logic [31:0] h, input logic [31:0] w,
                           input logic [31:0] cin, input logic [31:0] cout,
                           input logic [31:0] md, input logic [31:0] wa, input logic [31:0] st);
    cfg_write(idx, 0, h);
    cfg_write(idx, 1, w);
    cfg_write(idx, 2, cin);
    cfg_write(idx, 3, cout);
    cfg_write(idx, 4, md);
    cfg_write(idx, 5, wa);
    cfg_write(idx, 6, st);
  endtask

  function automatic logic [31:0] ofm_of(input int l, input int cnt);
    if (l == cnt - 1) return OUTA;
    return (l % 2 == 0) ? B1 : B0;
  endfunction

  task automatic wait_tile(input int lat, input string tag);
    int steps;
    steps = 0;
    do begin tick(); steps++; end while (!tile_start && !err && steps < 100);
    chk(tag, 64'(steps), 64'(lat));
  endtask

  // Run a whole network and compare every tile launch against the model's tile list.
  task automatic run(input int nl, input bit poke);
    int cnt, steps, dly, co;
    bit exp_err;
    tile_t t;
    cnt = (nl > ML) ? ML : nl;
    exp_q.delete();
    exp_err = 1'b0;
    for (int l = 0; l < cnt; l++) begin
      if (m_cout[l] == 16'd0 || m_mode[l] == 2'd3) begin exp_err = 1'b1; break; end
      co = int'(m_cout[l]);
      for (int b = 0; b < co; b += CT) begin
        t.layer = l;
        t.base  = 16'(b);
        t.len   = 16'((co - b > CT) ? CT : co - b);
        t.wa    = m_wa[l] + 32'(b / CT) * m_st[l];
        t.ifm   = (l == 0) ? IMG : ofm_of(l - 1, cnt);
        t.ofm   = ofm_of(l, cnt);
        t.first = (b == 0);
        exp_q.push_back(t);
      end
    end
    num_layers = 8'(nl); start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_cleared_by_start", 64'(err), 64'(0));
    chk("busy_after_start", 64'(busy), 64'(cnt != 0));
    for (int i = 0; i < exp_q.size(); i++) begin
      t = exp_q[i];
      wait_tile((i == 0) ? 2 : (t.first ? 3 : 2), "tile_latency");
      chk("layer_idx", 64'(layer_idx), 64'(t.layer));
      chk("H", 64'(H), 64'(m_h[t.layer]));
      chk("W", 64'(W), 64'(m_w[t.layer]));
      chk("Cin", 64'(Cin), 64'(m_cin[t.layer]));
      chk("Cout", 64'(Cout), 64'(m_cout[t.layer]));
      chk("mode", 64'(mode), 64'(m_mode[t.layer]));
      chk("cout_base", 64'(cout_base), 64'(t.base));
      chk("cout_len", 64'(cout_len), 64'(t.len));
      chk("weight_addr", 64'(weight_addr), 64'(t.wa));
      chk("ifm_addr", 64'(ifm_addr), 64'(t.ifm));
      chk("ofm_addr", 64'(ofm_addr), 64'(t.ofm));
      tick();
      chk("tile_start_one_cycle", 64'(tile_start), 64'(0));
      chk("busy_in_wait", 64'(busy), 64'(1));
      if (poke && i == 0) begin
        cfg_we = 1'b1; cfg_idx = 8'd0; cfg_field = 3'd3; cfg_wdata = 32'd5; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        chk("start_while_busy_ignored", 64'(tile_start), 64'(0));
      end
      dly = int'($urandom_range(0, 4));
      repeat (dly) tick();
      tile_done = 1'b1;
      tick();
      tile_done = 1'b0;
    end
    steps = 0;
    do begin tick(); steps++; end while (!all_done && !err && !tile_start && steps < 100);
    chk("no_extra_tile_start", 64'(tile_start), 64'(0));
    if (exp_err) begin
      chk("err_latency", 64'(steps), 64'((exp_q.size() == 0) ? 1 : 2));
      chk("err_set", 64'(err), 64'(1));
    end else begin
      chk("all_done_latency", 64'(steps), 64'((exp_q.size() == 0) ? 1 : 2));
      chk("all_done_set", 64'(all_done), 64'(1));
    end
    chk("busy_after_run", 64'(busy), 64'(0));
    tick();
    chk("all_done_pulse", 64'(all_done), 64'(0));
    chk("err_state_after", 64'(err), 64'(exp_err));
  endtask

  initial begin
    int steps, n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_layers = 8'd0; cfg_we = 1'b0;
    cfg_idx = 8'd0; cfg_field = 3'd0; cfg_wdata = 32'd0; tile_done = 1'b0;
    repeat (3) tick();
    chk("rst_tile_start", 64'(tile_start), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_all_done", 64'(all_done), 64'(0));
    chk("rst_aborted", 64'(aborted), 64'(0));
    chk("rst_layer_idx", 64'(layer_idx), 64'(0));
    chk("rst_H", 64'(H), 64'(0));
    chk("rst_cout_len", 64'(cout_len), 64'(0));
    chk("rst_weight_addr", 64'(weight_addr), 64'(0));
    chk("rst_ofm_addr", 64'(ofm_addr), 64'(0));
    rst_n = 1'b1;
    tick();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    tick();
    chk("idle_tile_done_busy", 64'(busy), 64'(0));
    chk("idle_tile_done_start", 64'(tile_start), 64'(0));

    // Two-layer network: one tile then two tiles through BUF1
    set_layer(0, 224, 224, 3, 16, 0, 32'h1000_0000, 32'h0);
    set_layer(1, 112, 112, 16, 64, 2, 32'h1000_4000, 32'h800);
    run(2, 1'b0);

    // Cout=40 splits 32+8; table writes and start during the run are ignored
    set_layer(0, 56, 56, 64, 40, 1, 32'h2000_0000, 32'h400);
    run(1, 1'b1);
    run(1, 1'b0);

    run(0, 1'b0);

    // Randomized network with junk in the truncated upper bits
    for (int l = 0; l < 6; l++)
      set_layer(l, $urandom, $urandom, $urandom,
                ($urandom & 32'hFFFF_0000) | $urandom_range(1, 100),
                ($urandom & 32'hFFFF_FFFC) | $urandom_range(0, 2), $urandom, $urandom);
    run(6, 1'b0);

    // Layer count clamps to the table depth
    for (int l = 0; l < ML; l++)
      set_layer(l, $urandom_range(1, 300), $urandom_range(1, 300), $urandom_range(1, 64),
                $urandom_range(1, 40), $urandom_range(0, 2), $urandom, $urandom_range(0, 4096));
    run(200, 1'b0);

    // Abort together with tile_done
    set_layer(0, 32, 32, 8, 64, 0, 32'h3000_0000, 32'h100);
    set_layer(1, 16, 16, 64, 16, 2, 32'h3100_0000, 32'h100);
    num_layers = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_tile(2, "abort_first_tile");
    tick(); tick();
    abort = 1'b1; tile_done = 1'b1;
    tick();
    abort = 1'b0; tile_done = 1'b0;
    chk("abort_pulse", 64'(aborted), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_tile_start", 64'(tile_start), 64'(0));
    n = 0;
    repeat (20) begin
      tick();
      if (tile_start || aborted || all_done || busy) n++;
    end
    chk("abort_quiet", 64'(n), 64'(0));

    // Reset mid-run: abandoned without an aborted pulse, table retained
    num_layers = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_tile(2, "reset_run_first_tile");
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_aborted", 64'(aborted), 64'(0));
    chk("midrst_weight_addr", 64'(weight_addr), 64'(0));
    chk("midrst_layer_idx", 64'(layer_idx), 64'(0));
    rst_n = 1'b1;
    tick();
    run(2, 1'b0);

    // Watchdog: tile_done withheld
    set_layer(0, 8, 8, 8, 16, 0, 32'h4000_0000, 32'h0);
    num_layers = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_tile(2, "timeout_first_tile");
    steps = 0;
    do begin tick(); steps++; end while (!err && steps < TO + 20);
    chk("timeout_latency", 64'(steps), 64'(TO));
    chk("timeout_busy", 64'(busy), 64'(0));
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    tick();
    chk("err_sticky", 64'(err), 64'(1));
    chk("err_no_tile_start", 64'(tile_start), 64'(0));
    run(1, 1'b0);

    // Bad entries: Cout=0, then mode=3
    set_layer(0, 10, 10, 4, 48, 0, 32'h5000_0000, 32'h200);
    set_layer(1, 10, 10, 48, 0, 0, 32'h5100_0000, 32'h200);
    set_layer(2, 10, 10, 48, 16, 0, 32'h5200_0000, 32'h200);
    run(3, 1'b0);
    set_layer(1, 10, 10, 48, 16, 3, 32'h5100_0000, 32'h200);
    run(2, 1'b0);
    set_layer(0, 10, 10, 4, 0, 1, 32'h5000_0000, 32'h200);
    run(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
